// File: rtl/mul16_seq.sv
// Shift-add 16x16 -> low-16 multiplier: one add per cycle, N = 16 (or highest set bit of b + 1 with EARLY_EXIT).
// Latency N edges from accept to done; start is accepted only while ready (IDLE/DONE), ignored in RUN.
module mul16_seq #(
  parameter int EARLY_EXIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [15:0] mcand;
  logic [15:0] mplr;
  logic [15:0] acc;
  logic [3:0]  cnt;

  logic [15:0] acc_nxt;
  logic        last_iter;
  logic        zero_skip;

  // Single adder; carry out of bit 15 is dropped, which also makes signed operands work.
  assign acc_nxt   = mplr[0] ? (acc + mcand) : acc;
  assign last_iter = (cnt == 4'd15) || ((EARLY_EXIT != 0) && (mplr[15:1] == 15'd0));
  assign zero_skip = (EARLY_EXIT != 0) && (b == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= 16'd0;
      mcand <= 16'd0;
      mplr  <= 16'd0;
      acc   <= 16'd0;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand <= a;
            mplr  <= b;
            acc   <= 16'd0;
            cnt   <= 4'd0;
            if (zero_skip) begin
              state <= DONE;
              out   <= 16'd0;
              ready <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              ready <= 1'b0;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          mcand <= {mcand[14:0], 1'b0};
          mplr  <= {1'b0, mplr[15:1]};
          cnt   <= cnt + 4'd1;
          // Result is captured from this edge's sum, not the registered acc.
          if (last_iter) begin
            state <= DONE;
            out   <= acc_nxt;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
// Directed bench for mul16_seq: one instance with early exit, one running fixed 16 iterations.
module tb_mul16_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0;
  logic        start0 = 1'b0;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic        ready1, busy1, done1;
  logic        ready0, busy0, done0;
  logic [15:0] out1, out0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul16_seq #(.EARLY_EXIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b),
    .ready(ready1), .busy(busy1), .done(done1), .out(out1)
  );

  mul16_seq #(.EARLY_EXIT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a), .b(b),
    .ready(ready0), .busy(busy0), .done(done0), .out(out0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one single-cycle start and measure latency, busy cycles, result and pulse width.
  task automatic do_op(input bit ee, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic [15:0] exp_out, input int exp_n, input string tag);
    int  n;
    int  bsy;
    bit  got;
    @(negedge clk);
    a = ta;
    b = tb_v;
    if (ee) start1 = 1'b1; else start0 = 1'b1;
    n = -1;
    bsy = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      start1 = 1'b0;
      start0 = 1'b0;
      n++;
      if (ee ? busy1 : busy0) bsy++;
      if (ee ? done1 : done0) got = 1'b1;
    end
    check({tag, " done seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, n, exp_n);
    check({tag, " busy cycles"}, bsy, exp_n);
    check({tag, " out"}, 32'(ee ? out1 : out0), 32'(exp_out));
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, 32'(ee ? done1 : done0), 32'd0);
    check({tag, " ready after"}, 32'(ee ? ready1 : ready0), 32'd1);
    check({tag, " out held"}, 32'(ee ? out1 : out0), 32'(exp_out));
  endtask

  initial begin
    int         dcnt;
    int         d_at [2];
    logic [15:0] d_out [2];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst ready", 32'(ready1), 32'd1);
    check("rst busy", 32'(busy1), 32'd0);
    check("rst done", 32'(done1), 32'd0);
    check("rst out", 32'(out1), 32'd0);
    check("rst ready ee0", 32'(ready0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b1, 16'd3, 16'd5, 16'h000F, 3, "3x5");
    do_op(1'b1, 16'h1234, 16'd0, 16'h0000, 0, "b0 early");
    do_op(1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 16, "ffff sq");
    do_op(1'b1, 16'h8000, 16'd2, 16'h0000, 2, "8000x2");
    do_op(1'b1, 16'h1234, 16'h0010, 16'h2340, 5, "1234x10");
    do_op(1'b1, 16'hFFFD, 16'd5, 16'hFFF1, 3, "neg3x5");
    do_op(1'b0, 16'h00AB, 16'd1, 16'h00AB, 16, "ee0 abx1");
    do_op(1'b0, 16'd5, 16'd0, 16'h0000, 16, "ee0 b0");

    // Handshake: start held high, second job taken in the DONE cycle
    @(negedge clk);
    a = 16'd7;
    b = 16'd6;
    start1 = 1'b1;
    dcnt = 0;
    d_at[0] = -1; d_at[1] = -1;
    d_out[0] = 16'd0; d_out[1] = 16'd0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        a = 16'hFFFF;
        b = 16'd3;
      end
      if (i == 2) check("hs run ignores start", 32'(busy1), 32'd1);
      if (done1) begin
        if (dcnt < 2) begin
          d_at[dcnt]  = i;
          d_out[dcnt] = out1;
        end
        dcnt++;
        if (dcnt == 2) start1 = 1'b0;
      end
    end
    start1 = 1'b0;
    check("hs done count", dcnt, 2);
    check("hs first at", d_at[0], 3);
    check("hs first out", 32'(d_out[0]), 32'h002A);
    check("hs second at", d_at[1], 6);
    check("hs second out", 32'(d_out[1]), 32'hFFFD);

    // Abort: asynchronous reset in the middle of a run
    @(negedge clk);
    a = 16'h1234;
    b = 16'hFFFF;
    start1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      start1 = 1'b0;
    end
    check("abort busy before", 32'(busy1), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort ready", 32'(ready1), 32'd1);
    check("abort busy", 32'(busy1), 32'd0);
    check("abort done", 32'(done1), 32'd0);
    check("abort out", 32'(out1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done1) dcnt++;
    end
    check("abort no done", dcnt, 0);
    check("abort out stays", 32'(out1), 32'd0);
    do_op(1'b1, 16'd2, 16'd2, 16'h0004, 2, "after abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul16_seq.md
MUL16_SEQ -- requirements
Module: mul16_seq

Interface
REQ-001 The block SHALL have parameter EARLY_EXIT, default 1, meaning: 1 ends the run once the remaining multiplier bits are all zero, 0 always runs 16 iterations.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply, sampled on the rising edge.
REQ-005 The block SHALL have port a, input, 16 bits: multiplicand, sampled only on the accepting edge.
REQ-006 The block SHALL have port b, input, 16 bits: multiplier, sampled only on the accepting edge.
REQ-007 The block SHALL have port ready, output, 1 bit: high when a start will be accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high while iterations are in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a new valid out.
REQ-010 The block SHALL have port out, output, 16 bits: low 16 bits of a*b, held until the next done.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 ready SHALL be 1 in IDLE and DONE and 0 in RUN; busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-013 On an accepting edge (start=1 and ready=1), the block SHALL load internal regs MCAND=a, MPLR=b, ACC=0 and CNT=0.
REQ-014 On an accepting edge, the FSM SHALL go to DONE with out=0 if EARLY_EXIT=1 and b==0; otherwise it SHALL go to RUN.
REQ-015 Each RUN edge SHALL perform exactly one 16-bit addition: ACC<=ACC+MCAND if MPLR[0]=1, else ACC unchanged; MCAND<=MCAND<<1; MPLR<=MPLR>>1; CNT<=CNT+1.
REQ-016 All sums and shifts SHALL be 16-bit modulo 2^16; carry-out and shifted-out bits SHALL be discarded, with no overflow flag.
REQ-017 RUN SHALL exit to DONE on the edge where CNT==15, or, when EARLY_EXIT=1, on the edge where MPLR>>1==0.
REQ-018 On the RUN exit edge, out SHALL load the post-addition ACC value of that same edge.
REQ-019 Latency from the accepting edge to the edge that raises done SHALL be N edges, where N=16 when EARLY_EXIT=0.
REQ-020 When EARLY_EXIT=1, N SHALL be 0 for b==0, otherwise 1 + the index of the highest set bit of b.
REQ-021 In DONE, for exactly one cycle, the FSM SHALL go to RUN (or DONE again per REQ-014) if start=1, else to IDLE.
REQ-022 Back-to-back operations SHALL produce one done pulse per accepted start.
REQ-023 start SHALL be ignored in RUN, with no effect on state, out or the operands in flight; a and b SHALL be don't-care outside the accepting edge.
REQ-024 out SHALL change only on an edge that enters DONE, or on reset.
REQ-025 Results SHALL be correct for two's-complement operands, because only the low 16 bits are produced.

Reset
REQ-026 While rst_n=0, regardless of clk, the block SHALL force state=IDLE, ready=1, busy=0, done=0, out=0x0000, and ACC, MCAND, MPLR and CNT to 0.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse.
REQ-028 After reset is released, the first accepting edge SHALL start a fresh operation.

Verification
REQ-029 The bench SHALL cover reset: rst_n=0 applied asynchronously mid-cycle -> immediately ready=1, busy=0, done=0, out=0x0000.
REQ-030 The bench SHALL cover the basic case: EARLY_EXIT=1, a=3, b=5, start for 1 cycle -> busy for 3 cycles, done after the 3rd edge, out=0x000F.
REQ-031 The bench SHALL cover the boundaries: b=0 with EARLY_EXIT=1 -> done after the accepting edge, out=0.
REQ-032 The bench SHALL cover wrap: a=0xFFFF, b=0xFFFF -> N=16, out=0x0001; and a=0x8000, b=2 -> out=0x0000.
REQ-033 The bench SHALL cover the handshake: start held high throughout a=7, b=6 followed by a=0xFFFF, b=3 -> second job accepted in the DONE cycle; done pulses exactly twice; outs 0x002A then 0xFFFD; RUN ignores start.
REQ-034 The bench SHALL cover abort: rst_n pulsed low at CNT=5 of a=0x1234, b=0xFFFF -> IDLE, out=0, no done; a new start (a=2, b=2) then gives out=0x0004.
